// File: rtl/hgcal_input_pkg.sv
// Shared definitions for the HGCAL input front end: code width, default
// frame geometry and quantizer thresholds, and the framing FSM states.
package hgcal_input_pkg;

  localparam int CODE_W           = 2;
  localparam int NUM_CHANNELS_DEF = 48;
  localparam int SAMPLE_W_DEF     = 10;
  localparam int T0_DEF           = -128;
  localparam int T1_DEF           = 0;
  localparam int T2_DEF           = 128;

  typedef enum logic {
    COLLECT = 1'b0,
    RESYNC  = 1'b1
  } state_e;

endpackage

// File: rtl/hgcal_input_quantizer.sv
// Combinational per-cell quantizer: a signed sample becomes a 2-bit code
// equal to the number of thresholds it meets or exceeds.
module hgcal_input_quantizer #(
  parameter int SAMPLE_W = hgcal_input_pkg::SAMPLE_W_DEF,
  parameter int T0       = hgcal_input_pkg::T0_DEF,
  parameter int T1       = hgcal_input_pkg::T1_DEF,
  parameter int T2       = hgcal_input_pkg::T2_DEF
) (
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic        [1:0]          o_code
);

  localparam logic signed [SAMPLE_W-1:0] TH0 = SAMPLE_W'(T0);
  localparam logic signed [SAMPLE_W-1:0] TH1 = SAMPLE_W'(T1);
  localparam logic signed [SAMPLE_W-1:0] TH2 = SAMPLE_W'(T2);

  logic w_ge0;
  logic w_ge1;
  logic w_ge2;

  assign w_ge0  = (i_sample >= TH0);
  assign w_ge1  = (i_sample >= TH1);
  assign w_ge2  = (i_sample >= TH2);
  assign o_code = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs a serial stream of quantized samples into one wide frame vector,
// with framing-error recovery and a one-frame holding buffer.
module hgcal_input_packer #(
  parameter int NUM_CHANNELS = hgcal_input_pkg::NUM_CHANNELS_DEF,
  parameter int SAMPLE_W     = hgcal_input_pkg::SAMPLE_W_DEF,
  parameter int CODE_W       = hgcal_input_pkg::CODE_W,
  parameter int T0           = hgcal_input_pkg::T0_DEF,
  parameter int T1           = hgcal_input_pkg::T1_DEF,
  parameter int T2           = hgcal_input_pkg::T2_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [SAMPLE_W-1:0]     s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_CHANNELS*CODE_W-1:0] m_data,
  output logic                           err_frame
);

  import hgcal_input_pkg::*;

  localparam int                OUT_W    = NUM_CHANNELS * CODE_W;
  localparam int                CNT_W    = $clog2(NUM_CHANNELS);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_CHANNELS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] r_asm;
  logic [OUT_W-1:0] w_asm_nxt;
  logic [OUT_W-1:0] r_mdata;
  logic             r_mvalid;
  logic             r_pending;
  logic             r_err;
  logic [1:0]       w_code;
  logic             w_accept;
  logic             w_slot_free;
  logic             w_wr;
  logic             w_done;
  logic             w_err;

  hgcal_input_quantizer #(
    .SAMPLE_W (SAMPLE_W),
    .T0       (T0),
    .T1       (T1),
    .T2       (T2)
  ) u_quant (
    .i_sample (s_data),
    .o_code   (w_code)
  );

  assign s_ready     = !r_pending && !rst;
  assign w_accept    = s_valid && s_ready;
  assign w_slot_free = !r_mvalid || m_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      case (r_state)
        COLLECT: begin
          w_wr = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_cnt_nxt = '0;
            if (s_last) begin
              w_done = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = RESYNC;
            end
          end else if (s_last) begin
            w_err     = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RESYNC: begin
          if (s_last) w_state_nxt = COLLECT;
        end
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  // The completing beat's code is merged here so the whole frame can load in one edge.
  always_comb begin
    w_asm_nxt = r_asm;
    if (w_wr) w_asm_nxt[r_cnt*CODE_W +: CODE_W] = CODE_W'(w_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output slot: a fresh frame and a pending drain are mutually exclusive,
  // since input is stalled whenever a frame is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm     <= '0;
      r_mdata   <= '0;
      r_mvalid  <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_asm <= w_asm_nxt;
      r_err <= w_err;
      if (w_done && w_slot_free) begin
        r_mdata  <= w_asm_nxt;
        r_mvalid <= 1'b1;
      end else if (w_done) begin
        r_pending <= 1'b1;
      end else if (r_pending && w_slot_free) begin
        r_mdata   <= r_asm;
        r_mvalid  <= 1'b1;
        r_pending <= 1'b0;
      end else if (m_ready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_mvalid;
  assign m_data    = r_mdata;
  assign err_frame = r_err;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Self-checking bench for hgcal_input_packer: directed scenarios plus random
// framing and backpressure against a frame-level queue model.
module tb_hgcal_input_packer;

  localparam int N  = 48;
  localparam int SW = 10;
  localparam int OW = N * 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          err_frame;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_err   = 0;
  logic [OW-1:0] last_out = '0;

  // Frame-level reference: completed frames not yet taken downstream.
  logic [OW-1:0] q[$];
  logic [1:0]    fr[$];
  bit            resync  = 1'b0;
  bit            exp_err = 1'b0;
  bit            rnd_done;

  hgcal_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] qref(input int s);
    if (s < -128) return 2'd0;
    if (s < 0)    return 2'd1;
    if (s < 128)  return 2'd2;
    return 2'd3;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    logic [OW-1:0] v;
    if (rst) begin
      q.delete();
      fr.delete();
      resync  = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      acc = s_valid && (q.size() < 2);
      if (q.size() > 0 && m_ready) begin
        last_out = m_data;
        n_out++;
        q.delete(0);
      end
      if (acc) begin
        if (resync) begin
          if (s_last) resync = 1'b0;
        end else begin
          fr.push_back(qref(int'($signed(s_data))));
          if (s_last) begin
            if (fr.size() == N) begin
              v = '0;
              foreach (fr[i]) v[i*2 +: 2] = fr[i];
              q.push_back(v);
            end else begin
              exp_err = 1'b1;
            end
            fr.delete();
          end else if (fr.size() == N) begin
            exp_err = 1'b1;
            resync  = 1'b1;
            fr.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready", OW'(s_ready), OW'(!rst && (q.size() < 2)));
    chk("m_valid", OW'(m_valid), OW'(q.size() > 0));
    if (q.size() > 0) chk("m_data", m_data, q[0]);
    chk("err_frame", OW'(err_frame), OW'(exp_err));
    if (err_frame) n_err++;
  end

  task automatic send(input logic [SW-1:0] d, input bit l);
    int  t;
    bit  done;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      if (s_ready) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 2000) begin
          n_tests++;
          n_fail++;
          $display("FAIL send_timeout: got no s_ready expected acceptance within 2000 cycles");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // kind 0: zeros, 1: threshold ramp, 2: random samples.
  task automatic send_frame(input int len, input bit with_last, input int kind);
    logic [SW-1:0] ramp[4];
    logic [SW-1:0] d;
    ramp[0] = SW'(-129);
    ramp[1] = SW'(-128);
    ramp[2] = SW'(127);
    ramp[3] = SW'(128);
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       d = '0;
        1:       d = ramp[i % 4];
        default: d = SW'($urandom_range(0, 1023));
      endcase
      send(d, with_last && (i == len - 1));
    end
  endtask

  initial begin
    int base_out;
    int base_err;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mdata", m_data, '0);
    rst = 1'b0;

    send_frame(N, 1'b1, 0);
    idle(2);
    chk("zeros_data", last_out, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("zeros_cnt", OW'(n_out), OW'(1));

    send_frame(N, 1'b1, 1);
    idle(2);
    chk("ramp_data", last_out, 96'hE4E4_E4E4_E4E4_E4E4_E4E4_E4E4);

    base_out = n_out;
    m_ready  = 1'b0;
    send_frame(N, 1'b1, 2);
    send_frame(N, 1'b1, 2);
    idle(100);
    chk("bp_sready", OW'(s_ready), OW'(0));
    chk("bp_held", OW'(n_out), OW'(base_out));
    m_ready = 1'b1;
    idle(3);
    chk("bp_release", OW'(n_out), OW'(base_out + 2));

    base_out = n_out;
    base_err = n_err;
    send_frame(11, 1'b1, 2);
    send_frame(N, 1'b1, 2);
    idle(3);
    chk("short_err", OW'(n_err), OW'(base_err + 1));
    chk("short_next", OW'(n_out), OW'(base_out + 1));

    base_out = n_out;
    base_err = n_err;
    send_frame(N, 1'b0, 2);
    send_frame(5, 1'b0, 2);
    send(SW'(0), 1'b1);
    idle(2);
    chk("long_noout", OW'(n_out), OW'(base_out));
    send_frame(N, 1'b1, 1);
    idle(3);
    chk("long_err", OW'(n_err), OW'(base_err + 1));
    chk("long_next", OW'(n_out), OW'(base_out + 1));
    chk("long_data", last_out, 96'hE4E4_E4E4_E4E4_E4E4_E4E4_E4E4);

    m_ready = 1'b0;
    send_frame(N, 1'b1, 2);
    send_frame(30, 1'b0, 2);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("rst_mid_mvalid", OW'(m_valid), OW'(0));
    chk("rst_mid_mdata", m_data, '0);
    rst = 1'b0;
    send_frame(N, 1'b1, 2);
    send_frame(N, 1'b1, 2);
    idle(3);
    chk("rst_pend_sready", OW'(s_ready), OW'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pend_mvalid", OW'(m_valid), OW'(0));
    chk("rst_pend_err", OW'(err_frame), OW'(0));
    rst      = 1'b0;
    m_ready  = 1'b1;
    base_out = n_out;
    send_frame(N, 1'b1, 0);
    idle(2);
    chk("rst_fresh_cnt", OW'(n_out), OW'(base_out + 1));
    chk("rst_fresh_data", last_out, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA);

    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 8) begin
            send_frame(N, 1'b1, 2);
          end else if (r == 8) begin
            send_frame($urandom_range(1, N - 1), 1'b1, 2);
          end else begin
            send_frame(N, 1'b0, 2);
            send_frame($urandom_range(0, 3), 1'b0, 2);
            send(SW'($urandom_range(0, 1023)), 1'b1);
          end
          idle($urandom_range(0, 2));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    m_ready = 1'b1;
    idle(6);
    chk("final_drained", OW'(m_valid), OW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hgcal_input_packer.md
# hgcal_input_packer

Upstream front end of the HGCAL autoencoder LogicNets pipeline. It accepts a serial stream of signed per-cell samples, one sample per beat. Each sample is quantized to a 2-bit code by signed threshold compares. A frame of NUM_CHANNELS codes is packed into the wide input vector that the first neuron layer consumes. Valid/ready handshakes on both sides, plus a one-frame holding buffer, decouple the sample stream from the downstream register stage.

## Interface
Parameters:
- NUM_CHANNELS, 48, cells per frame; output width is NUM_CHANNELS*CODE_W.
- SAMPLE_W, 10, signed sample width.
- CODE_W, 2, code width; fixed at 2.
- T0, -128, lowest signed threshold.
- T1, 0, middle signed threshold.
- T2, 128, highest signed threshold. Requires T0 < T1 < T2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready.
- s_data  in  SAMPLE_W  signed sample, two's complement.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream ready.
- m_data  out  NUM_CHANNELS*CODE_W  packed codes; channel i at bits [i*CODE_W +: CODE_W].
- err_frame  out  1  one-cycle pulse on a framing error.

## Operation
- **Quantize:** code = (s>=T0)+(s>=T1)+(s>=T2), signed compares, range 0..3. Example with defaults: -129→0, -128→1, 0→2, 127→2, 128→3.
- **Beats:** a beat is accepted when s_valid && s_ready. The code of an accepted beat is written into the assembly buffer at slot cnt, and cnt increments.
- **FSM states: COLLECT, RESYNC.**
  - COLLECT, beat accepted with cnt==NUM_CHANNELS-1 and s_last=1: the frame is complete and cnt returns to 0.
  - COLLECT, beat accepted with s_last=1 and cnt<NUM_CHANNELS-1 (short frame): partial frame discarded, err_frame pulses, cnt returns to 0, FSM stays in COLLECT.
  - COLLECT, beat accepted with cnt==NUM_CHANNELS-1 and s_last=0 (long frame): frame discarded, err_frame pulses, cnt returns to 0, FSM goes to RESYNC.
  - RESYNC: accepted beats are dropped. The first accepted beat with s_last=1 returns the FSM to COLLECT with cnt=0. That beat is also dropped and raises no further error.
- **Hand-off at frame complete:**
  - If the output slot is free (!m_valid, or m_valid && m_ready in the same cycle), the full vector, including the last beat's code, loads into m_data.
  - Otherwise the pending flag is set and the vector is held in the assembly buffer.
- **s_ready = !pending && !rst.** Input stalls only while a completed frame waits for the output slot.
- **Pending drain:** while pending, the vector loads into m_data on the first cycle with !m_valid || m_ready, and pending clears in that same cycle.
- **Output hold:** m_data and m_valid stay stable while m_valid && !m_ready.
- **Reset values:** m_valid=0, m_data=0, err_frame=0, pending=0, cnt=0, state=COLLECT, assembly buffer cleared. Reset mid-frame discards all partial and held frames.

## Timing
- Latency: m_valid rises 1 cycle after the accepted last beat when the output slot is free.
- Throughput: one sample per cycle sustained when m_ready is held high. There is no bubble between frames.
- Backpressure: a held frame releases on the cycle m_ready is seen. s_ready returns high the following cycle.
- err_frame: asserted the cycle after the offending beat, for exactly one cycle.
- Simultaneous load and drain: when m_valid && m_ready coincide with a frame load, the output register is overwritten. m_valid stays high and no frame is lost or duplicated.

## Structure
- **Shared package hgcal_input_pkg:** CODE_W, default NUM_CHANNELS, default thresholds, state enum {COLLECT, RESYNC}.
- **Sub-module hgcal_input_quantizer:** combinational, SAMPLE_W signed in, 2-bit code out, thresholds as parameters. Reused by any later per-cell quantizing front end.
- **Top holds:** cnt (clog2(NUM_CHANNELS) bits), assembly buffer, pending flag, output register, FSM.

## Test plan
- 48 beats of s_data=0, s_last on beat 47, m_ready=1 → m_valid one cycle after beat 47; m_data = {48{2'b10}} = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA.
- Ramp on channel i: s_data ∈ {-129,-128,127,128} cycled → codes 0,1,2,3 at bits [2i+:2] for every channel; no code bleeds into a neighbouring slot.
- Two back-to-back frames with m_ready=0 for 100 cycles → first frame held stable; second sets pending and s_ready=0 after its last beat; on m_ready=1 frame 1 then frame 2 appear on consecutive handshakes; none lost.
- s_last on beat 10 → err_frame pulse; next 48-beat frame is delivered correctly.
- 48 beats without s_last, then 5 junk beats, then s_last → err_frame pulses once; no m_valid; the following good frame is delivered.
- rst asserted at beat 30 of a frame, with another frame pending → all outputs at reset values next cycle; a fresh frame afterward is delivered intact.
